// File: rtl/updown_counter_n.sv
// updown_counter_n: parametrised up/down counter with modulus, load, enable,
// wrap/saturate selection, terminal-count flag and a registered boundary pulse.
module updown_counter_n #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MODULUS  = 10,
   parameter int unsigned SATURATE = 0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             m,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc,
   output logic             ovf
);

   // Range limits held one bit wider so MODULUS = 2**WIDTH does not alias to 0.
   localparam logic [WIDTH:0]   ModExt  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   LastExt = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] Last    = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   cnt_ext;
   logic [WIDTH:0]   d_ext;
   logic             at_top;
   logic             at_bottom;

   assign cnt_ext   = {1'b0, cnt_q};
   assign d_ext     = {1'b0, d};
   assign at_top    = (cnt_ext == LastExt);
   assign at_bottom = (cnt_q == '0);

   // Next-state: load beats count; boundary steps wrap or hold and raise ovf.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = 1'b0;
      if (load) begin
         cnt_d = (d_ext < ModExt) ? d : Last;
      end else if (en) begin
         if (!m) begin
            if (at_top) begin
               ovf_d = 1'b1;
               cnt_d = (SATURATE != 0) ? cnt_q : '0;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else begin
            if (at_bottom) begin
               ovf_d = 1'b1;
               cnt_d = (SATURATE != 0) ? cnt_q : Last;
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
      end
   end

   // State registers; clr clears count and pulse immediately.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign q   = cnt_q;
   assign qb  = ~cnt_q;
   assign ovf = ovf_q;
   // Zero-latency look-ahead: the next enabled edge hits a boundary.
   assign tc  = en & ((~m & at_top) | (m & at_bottom));

endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench for updown_counter_n: three instances (wrap, saturate, full-range 3-bit).
module tb_updown_counter_n;

   typedef struct packed {
      logic [1:0] inst;
      logic [3:0] q;
      logic       ovf;
      logic       tc;
   } exp_t;

   logic       clk;
   logic       clr  [3];
   logic       en   [3];
   logic       m    [3];
   logic       load [3];
   logic [3:0] d    [2];
   logic [2:0] d2;

   logic [3:0] q0, qb0, q1, qb1;
   logic [2:0] q2, qb2;
   logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

   exp_t  sb [$];
   string nq [$];
   event  sample_ev;
   int    checks = 0;
   int    passed = 0;

   updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
      .clk(clk), .clr(clr[0]), .en(en[0]), .m(m[0]), .load(load[0]), .d(d[0]),
      .q(q0), .qb(qb0), .tc(tc0), .ovf(ovf0)
   );

   updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
      .clk(clk), .clr(clr[1]), .en(en[1]), .m(m[1]), .load(load[1]), .d(d[1]),
      .q(q1), .qb(qb1), .tc(tc1), .ovf(ovf1)
   );

   updown_counter_n #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_full (
      .clk(clk), .clr(clr[2]), .en(en[2]), .m(m[2]), .load(load[2]), .d(d2),
      .q(q2), .qb(qb2), .tc(tc2), .ovf(ovf2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   task automatic push(input int i, input logic [3:0] eq, input logic eo, input logic et,
                       input string nm);
      exp_t e;
      e.inst = 2'(i);
      e.q    = eq;
      e.ovf  = eo;
      e.tc   = et;
      sb.push_back(e);
      nq.push_back(nm);
   endtask

   // One edge: drive at the falling edge, expectation checked just after the next rising edge.
   task automatic step(input int i, input logic c, input logic e, input logic mm, input logic ld,
                       input logic [3:0] dv, input logic [3:0] eq, input logic eo,
                       input logic et, input string nm);
      @(negedge clk);
      clr[i]  = c;
      en[i]   = e;
      m[i]    = mm;
      load[i] = ld;
      if (i == 2) d2 = dv[2:0];
      else d[i] = dv;
      push(i, eq, eo, et, nm);
   endtask

   // Monitor: compare every pending expectation against the DUT outputs.
   initial begin
      exp_t       it;
      string      nm;
      logic [3:0] aq, aqb, eqb;
      logic       ao, at;
      forever begin
         @(posedge clk or sample_ev);
         #1;
         while (sb.size() > 0) begin
            it = sb.pop_front();
            nm = nq.pop_front();
            eqb = ~it.q;
            case (it.inst)
               2'd0:    begin aq = q0; aqb = qb0; ao = ovf0; at = tc0; end
               2'd1:    begin aq = q1; aqb = qb1; ao = ovf1; at = tc1; end
               default: begin
                  aq = {1'b0, q2}; aqb = {1'b0, qb2}; ao = ovf2; at = tc2;
                  eqb[3] = 1'b0;
               end
            endcase
            checks++;
            if (aq === it.q && aqb === eqb && ao === it.ovf && at === it.tc) begin
               passed++;
            end else begin
               $display("FAIL %s (inst %0d): actual q=%0d qb=%h ovf=%b tc=%b, required q=%0d qb=%h ovf=%b tc=%b",
                        nm, it.inst, aq, aqb, ao, at, it.q, eqb, it.ovf, it.tc);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         clr[i] = 1'b0; en[i] = 1'b0; m[i] = 1'b0; load[i] = 1'b0;
      end
      d[0] = '0; d[1] = '0; d2 = '0;
      en[0] = 1'b1;
      m[0]  = 1'b1;

      // Reset state before any clock edge.
      #2;
      push(0, 4'd0, 1'b0, 1'b1, "rst_async_a");
      push(1, 4'd0, 1'b0, 1'b0, "rst_async_s");
      push(2, 4'd0, 1'b0, 1'b0, "rst_async_f");
      -> sample_ev;

      // Reset held with clock running and en high.
      step(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, "rst_hold_dn");
      step(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, "rst_hold_dn2");
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "rst_hold_up");

      // Up wrap: 12 edges from 0.
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, "rel_first");
      for (int k = 2; k <= 8; k++)
         step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'(k), 1'b0, 1'b0, "up");
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, "up_tc");
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "up_wrap");
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, "up_post1");
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, "up_post2");

      // Down wrap from a load of 2.
      step(0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0, "ld2");
      step(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, "dn1");
      step(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, "dn_tc");
      step(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0, "dn_wrap");
      step(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0, "dn_after");

      // Load priority, clamp, hold.
      step(0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 4'd9, 1'b0, 1'b1, "ld_clamp13");
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd9, 1'b0, 1'b0, "idle_hold");
      step(0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  4'd3, 1'b0, 1'b0, "ld_wins_boundary");
      step(0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd10, 4'd9, 1'b0, 1'b0, "ld_clamp10");

      // Saturate: from 7 up for 5 edges, then reverse.
      step(1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, "sat_ld7");
      step(1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0, "sat_up8");
      step(1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, "sat_up9");
      for (int k = 0; k < 3; k++)
         step(1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1, "sat_hold_top");
      step(1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0, "sat_dir_change");
      step(1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, "sat_ld1");
      step(1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, "sat_dn_tc");
      step(1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, "sat_hold_bot");

      // Full range 3-bit, modulus 8.
      for (int k = 1; k <= 6; k++)
         step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'(k), 1'b0, 1'b0, "w3_up");
      step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd7, 1'b0, 1'b1, "w3_tc");
      step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "w3_wrap");
      for (int k = 1; k <= 5; k++)
         step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'(k), 1'b0, 1'b0, "w3_up2");

      // Async clear mid-cycle at q=5.
      @(negedge clk);
      #2;
      clr[2] = 1'b0;
      push(2, 4'd0, 1'b0, 1'b0, "w3_async_clr");
      -> sample_ev;
      step(2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "w3_clr_edge");
      step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, "w3_release");

      @(negedge clk);
      if (sb.size() != 0) begin
         $display("FAIL unchecked: actual=%0d pending required=0", sb.size());
         checks += sb.size();
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
